mips_fetch_stage: RTL
=====================

// Module: mips_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS core. Holds the PC and drives instr_address of the harvard RAM.
//  Captures the zero-delay instr_readdata into the IF/ID register. Applies branch/jump redirects with
//  MIPS delay-slot semantics, absorbs stalls, and halts the core when the PC reaches 0x00000000.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  first fetch address after reset
//  HALT_ADDR     32'h00000000  fetching this address ends execution
// PORTS
//  clk              in   1   single clock, all state on rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  stall            in   1   hold PC and IF/ID register (hazard/mem-wait from downstream)
//  redirect_valid   in   1   branch/jump in decode taken this cycle
//  redirect_target  in   32  new PC for redirect
//  instr_readdata   in   32  word from RAM at instr_address (same cycle)
//  instr_address    out  32  = pc register (combinational)
//  if_valid         out  1   IF/ID register holds a real instruction
//  if_instr         out  32  captured instruction
//  if_pc            out  32  address of if_instr
//  if_pc_plus8      out  32  if_pc + 8 (link value for JAL/BGEZAL)
//  active           out  1   core running; low in BOOT and after halt
//  fetch_exc        out  1   sticky: misaligned redirect target (AdEL on fetch)
//  instr_count      out  32  instructions captured since reset, wraps at 2^32
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_VECTOR, state=BOOT, if_valid=0, if_instr=0, if_pc=0,
//   active=0, fetch_exc=0, instr_count=0, redir_pend=0, redir_tgt=0. if_pc_plus8 = if_pc+8 always.
//  States: BOOT -> RUN -> HALTED; RUN -> FAULT. HALTED, FAULT terminal until reset.
//  BOOT: one edge after reset release; -> RUN, active<=1; no capture, pc unchanged.
//  RUN, stall=1: pc, if_* and count hold. redirect_valid=1 -> redir_pend<=1, redir_tgt<=target.
//  RUN, stall=0, pc!=HALT_ADDR: if_instr<=instr_readdata, if_pc<=pc, if_valid<=1, count+=1;
//   next pc = redirect_valid ? redirect_target : redir_pend ? redir_tgt : pc+4; clear redir_pend.
//   Live redirect beats pending one (both at once is illegal; bench asserts it never occurs).
//  Delay slot: redirect arrives while pc = branch+4, so the delay-slot word is captured on the
//   same edge the target is loaded; the delay slot is never squashed.
//  Latency: instruction at pc visible on if_instr one edge after pc presented; redirect -> first
//   target instruction on if_instr two edges after redirect edge (no stall).
//  Halt: RUN, stall=0, pc==HALT_ADDR: no capture, if_valid<=0, active<=0, state->HALTED.
//   Word at 0 is never fetched. HALTED: pc frozen, if_valid=0, inputs ignored.
//  Misaligned: selected next pc with [1:0]!=0 -> pc not updated, fetch_exc<=1, if_valid<=0,
//   active<=0, state->FAULT (delay slot captured that edge remains in if_instr, valid cleared).
//  pc+4 wraps mod 2^32 (0xFFFFFFFC -> 0x00000000, which then halts).
//  Reset asserted mid-operation: immediate return to reset values; pending redirect discarded.
// STRUCTURE
//  mips_pkg: RESET_VECTOR/HALT_ADDR defaults, typedef enum logic[1:0] {BOOT,RUN,HALTED,FAULT}
//   fetch_state_t. Single module; next-PC mux inline, no sub-module warranted.
// TESTING
//  1 Reset, release, stall=0, RAM seq words -> instr_address BFC00000,BFC00004..; if_pc lags by 1;
//    active 0 during BOOT edge, then 1; instr_count increments per edge.
//  2 redirect_valid with target 0xBFC00100 while pc=0xBFC00008 -> if_pc 0xBFC00008 (delay slot)
//    then 0xBFC00100; if_pc_plus8 = if_pc+8 each cycle.
//  3 redirect during stall (3 stall cycles), release -> pc jumps to pending target, pc/if_* held
//    throughout stall, count unchanged during stall.
//  4 JR to 0x00000000 -> delay slot captured, next edge if_valid=0, active=0, instr_address stays 0,
//    further redirects ignored.
//  5 redirect target 0xBFC00102 -> fetch_exc=1, active=0, pc unchanged, state FAULT until reset.
//  6 reset_n pulsed low asynchronously mid-stall with pending redirect -> all outputs reset
//    immediately; after release fetch restarts at 0xBFC00000, no redirect applied.

Source files
------------

// File: rtl/mips_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage.
//  DEFAULT_RESET_VECTOR  first fetch address after reset
//  DEFAULT_HALT_ADDR     fetching this address ends execution
//  fetch_state_t         BOOT -> RUN -> HALTED, RUN -> FAULT
//  is_word_aligned       true when the two low address bits are zero
package mips_fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Bundle between the fetch stage, the instruction RAM and the decode stage.
//  stall, redirect_valid, redirect_target  control from decode/hazard logic
//  instr_address / instr_readdata          zero-delay instruction RAM port
//  if_valid, if_instr, if_pc, if_pc_plus8  IF/ID pipeline register contents
// Modport master is the fetch stage; slave is everything around it.
interface mips_fetch_stage_if;

  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_readdata;
  logic [31:0] instr_address;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus8;

  modport master (
    input  stall, redirect_valid, redirect_target, instr_readdata,
    output instr_address, if_valid, if_instr, if_pc, if_pc_plus8
  );

  modport slave (
    output stall, redirect_valid, redirect_target, instr_readdata,
    input  instr_address, if_valid, if_instr, if_pc, if_pc_plus8
  );

endinterface

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage of the MIPS core.
//  clk          single clock, all state on the rising edge
//  reset_n      asynchronous active-low reset
//  bus          fetch-side view of mips_fetch_stage_if (RAM port, control, IF/ID register)
//  active       core running; low during BOOT and after halt/fault
//  fetch_exc    sticky misaligned-redirect flag (AdEL on fetch)
//  instr_count  instructions captured since reset, wraps at 2^32
// Redirects follow MIPS delay-slot semantics: the word at the current pc
// (the delay slot) is always captured on the edge the target is loaded.
module mips_fetch_stage
  import mips_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic                        clk,
  input  logic                        reset_n,
  mips_fetch_stage_if.master          bus,
  output logic                        active,
  output logic                        fetch_exc,
  output logic [31:0]                 instr_count
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         if_valid_reg, if_valid_next;
  logic [31:0]  if_instr_reg, if_instr_next;
  logic [31:0]  if_pc_reg, if_pc_next;
  logic         active_reg, active_next;
  logic         fetch_exc_reg, fetch_exc_next;
  logic [31:0]  count_reg, count_next;
  logic         redir_pend_reg, redir_pend_next;
  logic [31:0]  redir_tgt_reg, redir_tgt_next;

  logic [31:0]  pc_plus4;
  logic [31:0]  pc_sel;

  assign pc_plus4 = pc_reg + 32'd4;  // wraps to 0, which then halts

  // A live redirect wins over one remembered from a stall.
  assign pc_sel = bus.redirect_valid ? bus.redirect_target :
                  redir_pend_reg     ? redir_tgt_reg       :
                                       pc_plus4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_VECTOR;
      if_valid_reg   <= 1'b0;
      if_instr_reg   <= 32'd0;
      if_pc_reg      <= 32'd0;
      active_reg     <= 1'b0;
      fetch_exc_reg  <= 1'b0;
      count_reg      <= 32'd0;
      redir_pend_reg <= 1'b0;
      redir_tgt_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      if_valid_reg   <= if_valid_next;
      if_instr_reg   <= if_instr_next;
      if_pc_reg      <= if_pc_next;
      active_reg     <= active_next;
      fetch_exc_reg  <= fetch_exc_next;
      count_reg      <= count_next;
      redir_pend_reg <= redir_pend_next;
      redir_tgt_reg  <= redir_tgt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    if_valid_next   = if_valid_reg;
    if_instr_next   = if_instr_reg;
    if_pc_next      = if_pc_reg;
    active_next     = active_reg;
    fetch_exc_next  = fetch_exc_reg;
    count_next      = count_reg;
    redir_pend_next = redir_pend_reg;
    redir_tgt_next  = redir_tgt_reg;

    unique case (state_reg)
      BOOT: begin
        // One settling edge after reset release; nothing is fetched yet.
        state_next  = RUN;
        active_next = 1'b1;
      end

      RUN: begin
        if (bus.stall) begin
          // Remember a redirect that arrives while the pipe is frozen.
          if (bus.redirect_valid) begin
            redir_pend_next = 1'b1;
            redir_tgt_next  = bus.redirect_target;
          end
        end else if (pc_reg == HALT_ADDR) begin
          // The word at the halt address is never captured.
          if_valid_next = 1'b0;
          active_next   = 1'b0;
          state_next    = HALTED;
        end else begin
          if_instr_next   = bus.instr_readdata;
          if_pc_next      = pc_reg;
          if_valid_next   = 1'b1;
          count_next      = count_reg + 32'd1;
          redir_pend_next = 1'b0;
          if (is_word_aligned(pc_sel[1:0])) begin
            pc_next = pc_sel;
          end else begin
            // The delay slot just captured stays visible for debug but is
            // marked invalid; pc keeps the faulting fetch's predecessor.
            fetch_exc_next = 1'b1;
            if_valid_next  = 1'b0;
            active_next    = 1'b0;
            state_next     = FAULT;
          end
        end
      end

      HALTED, FAULT: begin
        // Terminal until reset.
      end

      default: state_next = BOOT;
    endcase
  end

  assign bus.instr_address = pc_reg;
  assign bus.if_valid      = if_valid_reg;
  assign bus.if_instr      = if_instr_reg;
  assign bus.if_pc         = if_pc_reg;
  assign bus.if_pc_plus8   = if_pc_reg + 32'd8;
  assign active            = active_reg;
  assign fetch_exc         = fetch_exc_reg;
  assign instr_count       = count_reg;

endmodule
